// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execution unit: pipelined multiplier, iterative restoring divider,
// valid/ready on request and response. Define MULDIV_REUSE_EN to reuse the last DIV-path result.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned DIV_BITS   = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned DIV_ITERS = XLEN / DIV_BITS;
  localparam int unsigned CNT_MAX   = (DIV_ITERS > MUL_STAGES) ? DIV_ITERS : MUL_STAGES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_SPEC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [XLEN-1:0]  rs1_q, rs2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
  logic             neg_quo_q, neg_rem_q;

  logic             accept;
  logic             in_sgn, in_zero, in_ovf, in_hit;
  logic             in_neg1, in_neg2;
  logic [XLEN-1:0]  in_mag1, in_mag2;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = req_valid && req_ready && !flush;

  assign in_sgn  = !op[0];
  assign in_zero = (rs2 == '0);
  assign in_ovf  = in_sgn && (rs1 == MIN_INT) && (rs2 == '1);
  assign in_neg1 = in_sgn & rs1[XLEN-1];
  assign in_neg2 = in_sgn & rs2[XLEN-1];
  assign in_mag1 = in_neg1 ? -rs1 : rs1;
  assign in_mag2 = in_neg2 ? -rs2 : rs2;

`ifdef MULDIV_REUSE_EN
  logic             tag_valid;
  logic             tag_sgn;
  logic [XLEN-1:0]  tag_rs1, tag_rs2, tag_quo, tag_rem;
  logic             hit_q;

  assign in_hit = tag_valid && (tag_rs1 == rs1) && (tag_rs2 == rs2) && (tag_sgn == in_sgn);
`else
  assign in_hit = 1'b0;
`endif

  // State register and next-state logic
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A reuse hit takes the one-cycle SPEC route so its response lands one cycle after accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!op[2])                       state_d = S_MUL;
          else if (in_zero || in_ovf || in_hit) state_d = S_SPEC;
          else                              state_d = S_DIV;
        end
      end
      S_MUL:   if (cnt_q == '0) state_d = S_DONE;
      S_DIV:   if (cnt_q == '0) state_d = S_DONE;
      S_SPEC:  state_d = S_DONE;
      S_DONE:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Multiplier: operands extended to 2*XLEN so one product covers all signedness mixes
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod, mul_tap;
  logic [XLEN-1:0]   mul_res;

  assign mul_sa   = (op_q != 2'b11);
  assign mul_sb   = !op_q[1];
  assign mul_a    = {{XLEN{mul_sa & rs1_q[XLEN-1]}}, rs1_q};
  assign mul_b    = {{XLEN{mul_sb & rs2_q[XLEN-1]}}, rs2_q};
  assign mul_prod = mul_a * mul_b;

  generate
    if (MUL_STAGES > 1) begin : g_pipe
      logic [2*XLEN-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge clk) begin
        pipe[0] <= mul_prod;
        for (int unsigned k = 1; k < MUL_STAGES - 1; k++) pipe[k] <= pipe[k-1];
      end
      assign mul_tap = pipe[MUL_STAGES-2];
    end else begin : g_nopipe
      assign mul_tap = mul_prod;
    end
  endgenerate

  assign mul_res = (op_q == 2'b00) ? mul_tap[XLEN-1:0] : mul_tap[2*XLEN-1:XLEN];

  // Restoring divider: DIV_BITS quotient bits per cycle on magnitudes
  logic [XLEN:0]   div_r;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] quo_nx, rem_nx;

  always_comb begin
    div_r = {1'b0, rem_q};
    div_q = quo_q;
    for (int unsigned i = 0; i < DIV_BITS; i++) begin
      div_r = {div_r[XLEN-1:0], div_q[XLEN-1]};
      div_q = {div_q[XLEN-2:0], 1'b0};
      if (div_r >= {1'b0, dvs_q}) begin
        div_r    = div_r - {1'b0, dvs_q};
        div_q[0] = 1'b1;
      end
    end
    quo_nx = div_q;
    rem_nx = div_r[XLEN-1:0];
  end

  logic [XLEN-1:0] quo_fin, rem_fin, spec_quo, spec_rem, done_quo, done_rem, done_res;

  assign quo_fin = neg_quo_q ? -quo_q : quo_q;
  assign rem_fin = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    spec_quo = '1;
    spec_rem = rs1_q;
    if (rs2_q != '0) begin
      spec_quo = rs1_q;
      spec_rem = '0;
    end
`ifdef MULDIV_REUSE_EN
    if (hit_q) begin
      spec_quo = tag_quo;
      spec_rem = tag_rem;
    end
`endif
  end

  assign done_quo = (state_q == S_SPEC) ? spec_quo : quo_fin;
  assign done_rem = (state_q == S_SPEC) ? spec_rem : rem_fin;
  assign done_res = op_q[1] ? done_rem : done_quo;

  // Datapath and response registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
      result     <= '0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= op[1:0];
            rs1_q     <= rs1;
            rs2_q     <= rs2;
            quo_q     <= in_mag1;
            rem_q     <= '0;
            dvs_q     <= in_mag2;
            neg_quo_q <= in_neg1 ^ in_neg2;
            neg_rem_q <= in_neg1;
            cnt_q     <= op[2] ? CNT_W'(DIV_ITERS) : CNT_W'(MUL_STAGES - 1);
          end
        end
        S_MUL: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            result     <= mul_res;
            resp_valid <= 1'b1;
          end
        end
        S_DIV: begin
          if (cnt_q != '0) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
            cnt_q <= cnt_q - 1'b1;
          end else begin
            result     <= done_res;
            resp_valid <= 1'b1;
          end
        end
        S_SPEC: begin
          result     <= done_res;
          resp_valid <= 1'b1;
        end
        S_DONE: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MULDIV_REUSE_EN
  // Tag drops on any non-matching DIV-path accept and is rewritten when that op completes
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      tag_valid <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      if (accept && op[2]) begin
        hit_q <= in_hit;
        if (!in_hit) tag_valid <= 1'b0;
      end
      if (((state_q == S_DIV) && (cnt_q == '0)) || (state_q == S_SPEC)) begin
        tag_valid <= 1'b1;
        tag_rs1   <= rs1_q;
        tag_rs2   <= rs2_q;
        tag_sgn   <= !op_q[0];
        tag_quo   <= done_quo;
        tag_rem   <= done_rem;
      end
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops
// checked against an arithmetic reference model (result and response latency).
module tb_muldiv_unit;

  localparam int XLEN    = 32;
  localparam int MS      = 2;
  localparam int DB      = 1;
  localparam int DIV_LAT = XLEN / DB + 1;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      op = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Reference view of the reuse tag: last completed div/rem operands and signedness
  bit          tag_v = 1'b0;
  logic [31:0] tag_a, tag_b;
  bit          tag_s;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS), .DIV_BITS(DB)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .op(op), .rs1(rs1), .rs2(rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result), .busy(busy)
  );

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return MS;
    if (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_REUSE_EN
    if (tag_v && tag_a == a && tag_b == b && tag_s == !o[0]) return 1;
`endif
    return DIV_LAT;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int bp);
    logic [31:0] er;
    int          el, lat;
    bit          got;
    er = ref_res(o, a, b);
    el = exp_lat(o, a, b);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    #1 req_valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1 lat++;
      if (resp_valid) got = 1'b1;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("result", result, er);
    chk("busy_in_done", 32'(busy), 32'd1);
    repeat (bp) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_result", result, er);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    if (o[2]) begin tag_v = 1'b1; tag_a = a; tag_b = b; tag_s = !o[0]; end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    tag_v = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          seen;
    logic [31:0] pa, pb, a, b;
    logic [2:0]  o;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rstn = 1'b1;

    // Multiply
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd0, 32'd12345, 32'd0, 0);

    // Divide, with 10 cycles of backpressure on div 100/7
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 2);
    run_op(3'd4, 32'd100, 32'd7, 10);
    run_op(3'd6, 32'd100, 32'd7, 0);
    run_op(3'd6, 32'd100, 32'd8, 0);
    pulse_flush();
    run_op(3'd4, 32'd100, 32'd8, 0);
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);

    // Special cases
    run_op(3'd4, 32'd1234, 32'd0, 0);
    run_op(3'd6, 32'd5, 32'd0, 0);
    run_op(3'd5, 32'd77, 32'd0, 0);
    run_op(3'd7, 32'd77, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush at T+10 of a divide
    @(negedge clk);
    req_valid = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    tag_v = 1'b0;
    seen = 0;
    repeat (50) begin
      @(posedge clk);
      #1 if (resp_valid) seen++;
    end
    chk("flush_no_resp", 32'(seen), 32'd0);
    chk("flush_idle", 32'(busy), 32'd0);

    // Request coinciding with flush is dropped
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    chk("flush_req_dropped", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("flush_req_no_resp", 32'(resp_valid), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 0);

    // Reset mid-divide
    @(negedge clk);
    req_valid = 1'b1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk) rstn = 1'b1;
    tag_v = 1'b0;
    run_op(3'd5, 32'd1000, 32'd3, 0);

    // Randomized ops, sometimes repeating the previous operands to exercise reuse
    pa = 32'd1; pb = 32'd1;
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin a = pa; b = pb; end
      else begin a = pick(); b = pick(); end
      run_op(o, a, b, $urandom_range(0, 3));
      pa = a; pb = b;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
